fcims_txn_ctrl: RTL

FCIMS_TXN_CTRL -- requirements
Module: fcims_txn_ctrl

---
 rtl/fcims_txn_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fcims_txn_ctrl.sv
// ---------------------------------------------------------------------------
// fcims_txn_ctrl
// Stock / sales transaction controller. A request taken while idle either
// restocks (adds qty to stock) or sells (removes qty from stock and prices
// the sale with a 4-cycle shift-add multiply, total = uprice * qty).
// Rejected transactions (overflow past 15 or selling more than in stock)
// leave stock and total untouched and report err with the done pulse.
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   reset_n  in   asynchronous active-low reset
//   req      in   transaction request (level), sampled only when idle
//   op       in   0 = restock, 1 = sell
//   qty      in   [3:0] cell count
//   uprice   in   [3:0] unit price (sell only)
//   busy     out  high whenever a transaction is in progress
//   done     out  one-cycle completion pulse
//   err      out  1 = last transaction rejected, valid with done
//   stock    out  [3:0] current stock
//   total    out  [7:0] price of the last completed sell
// ---------------------------------------------------------------------------
module fcims_txn_ctrl #(
   parameter logic [3:0] INIT_STOCK = 4'd0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req,
   input  logic       op,
   input  logic [3:0] qty,
   input  logic [3:0] uprice,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [3:0] stock,
   output logic [7:0] total
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_MUL   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_reg;
   logic        op_reg;
   logic [3:0]  qty_reg;     // multiplier; shifted right one bit per MUL cycle
   logic [7:0]  mcand_reg;   // multiplicand; shifted left one bit per MUL cycle
   logic [7:0]  acc_reg;
   logic [1:0]  cnt_reg;
   logic [3:0]  stock_reg;
   logic [7:0]  total_reg;
   logic        err_reg;

   // Restock sum kept one bit wider so an overflow past 15 is visible
   // instead of wrapping.
   logic [4:0]  sum_w;
   logic [7:0]  acc_add_w;

   assign sum_w     = {1'b0, stock_reg} + {1'b0, qty_reg};
   assign acc_add_w = acc_reg + (qty_reg[0] ? mcand_reg : 8'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= S_IDLE;
         op_reg    <= 1'b0;
         qty_reg   <= 4'd0;
         mcand_reg <= 8'd0;
         acc_reg   <= 8'd0;
         cnt_reg   <= 2'd0;
         stock_reg <= INIT_STOCK;
         total_reg <= 8'd0;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (req) begin
                  op_reg    <= op;
                  qty_reg   <= qty;
                  mcand_reg <= {4'd0, uprice};
                  err_reg   <= 1'b0;
                  state_reg <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (!op_reg) begin
                  if (sum_w > 5'd15) begin
                     err_reg <= 1'b1;
                  end else begin
                     stock_reg <= sum_w[3:0];
                  end
                  state_reg <= S_DONE;
               end else if (qty_reg > stock_reg) begin
                  err_reg   <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  stock_reg <= stock_reg - qty_reg;
                  acc_reg   <= 8'd0;
                  cnt_reg   <= 2'd0;
                  state_reg <= S_MUL;
               end
            end

            S_MUL: begin
               // One multiplier bit per cycle, LSB first; the product is
               // published to total only on the last of the four cycles.
               acc_reg   <= acc_add_w;
               qty_reg   <= qty_reg >> 1;
               mcand_reg <= mcand_reg << 1;
               cnt_reg   <= cnt_reg + 2'd1;
               if (cnt_reg == 2'd3) begin
                  total_reg <= acc_add_w;
                  state_reg <= S_DONE;
               end
            end

            S_DONE: begin
               state_reg <= S_IDLE;
            end

            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign busy  = (state_reg != S_IDLE);
   assign done  = (state_reg == S_DONE);
   assign err   = err_reg;
   assign stock = stock_reg;
   assign total = total_reg;

endmodule
